// File: rtl/step_response_monitor.sv
// step_response_monitor: measures a filter's step response (peak, settling
// time, timeout) and streams a decimated trace through a small FIFO.
module step_response_monitor #(
    parameter int WIDTH        = 18,
    parameter int DECIM        = 4,
    parameter int SETTLE_COUNT = 16,
    parameter int TIMER_WIDTH  = 24,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [WIDTH-1:0]       v_in,
    input  logic [WIDTH-1:0]       target,
    input  logic [WIDTH-1:0]       tol,
    output logic [WIDTH-1:0]       m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   settled,
    output logic [TIMER_WIDTH-1:0] settle_time,
    output logic [WIDTH-1:0]       peak,
    output logic                   overflow
);
    localparam int CW = $clog2(SETTLE_COUNT + 1);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [WIDTH-1:0]       PEAK_INIT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]          CNT_MAX   = CW'(SETTLE_COUNT);
    localparam logic [PW-1:0]          PH_MAX    = PW'(DECIM - 1);
    localparam logic [AW:0]            FIFO_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [TIMER_WIDTH-1:0] RUN_OFS   = TIMER_WIDTH'(SETTLE_COUNT - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_TRACK = 2'd1, ST_DONE = 2'd2} state_t;

    state_t                 r_state, w_state_nxt;
    logic [TIMER_WIDTH-1:0] r_timer, r_settle_time;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [PW-1:0]          r_phase;
    logic [WIDTH-1:0]       r_peak;
    logic                   r_settled, r_overflow;
    logic                   w_track, w_arm, w_in_band, w_settle, w_timeout;
    logic                   w_push, w_pop, w_full, w_wr_en;
    logic signed [WIDTH:0]  w_diff, w_abs;
    logic [WIDTH-1:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [AW:0]            r_count;

    assign w_track = (r_state == ST_TRACK);
    // start is ignored while tracking; from IDLE or DONE it (re-)arms
    assign w_arm   = start && !w_track;

    // One extra bit keeps v_in - target from wrapping at the code extremes
    assign w_diff    = $signed({v_in[WIDTH-1], v_in}) - $signed({target[WIDTH-1], target});
    assign w_abs     = w_diff[WIDTH] ? -w_diff : w_diff;
    assign w_in_band = ($unsigned(w_abs) <= {1'b0, tol});

    // In-band run length: clears on any out-of-band sample, saturates at the goal
    always_comb begin
        w_cnt_nxt = '0;
        if (w_in_band)
            w_cnt_nxt = (r_cnt >= CNT_MAX) ? CNT_MAX : r_cnt + CW'(1);
    end

    assign w_settle  = w_track && w_in_band && (w_cnt_nxt == CNT_MAX);
    assign w_timeout = w_track && (&r_timer) && !w_settle;
    assign w_push    = w_track && (r_phase == '0);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state; settle wins over timeout because w_timeout excludes it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_TRACK;
            ST_TRACK: if (w_settle || w_timeout) w_state_nxt = ST_DONE;
            ST_DONE:  if (start) w_state_nxt = ST_TRACK;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (r_state == ST_TRACK);
        done = (r_state == ST_DONE);
    end

    // Measurement datapath: cleared on arm, updated every tracking cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer       <= '0;
            r_cnt         <= '0;
            r_phase       <= '0;
            r_peak        <= PEAK_INIT;
            r_settled     <= 1'b0;
            r_settle_time <= '0;
        end else if (w_arm) begin
            r_timer       <= '0;
            r_cnt         <= '0;
            r_phase       <= '0;
            r_peak        <= PEAK_INIT;
            r_settled     <= 1'b0;
            r_settle_time <= '0;
        end else if (w_track) begin
            r_timer <= r_timer + TIMER_WIDTH'(1);
            r_cnt   <= w_cnt_nxt;
            r_phase <= (r_phase == PH_MAX) ? '0 : r_phase + PW'(1);
            if ($signed(v_in) > $signed(r_peak))
                r_peak <= v_in;
            if (w_settle) begin
                // report where the final in-band run began, not where it completed
                r_settled     <= 1'b1;
                r_settle_time <= r_timer - RUN_OFS;
            end else if (w_timeout) begin
                r_settled     <= 1'b0;
                r_settle_time <= '1;
            end
        end
    end

    assign settled     = r_settled;
    assign settle_time = r_settle_time;
    assign peak        = r_peak;
    assign overflow    = r_overflow;

    // Trace FIFO; a full FIFO still accepts a push when the head leaves that cycle
    assign m_valid = (r_count != '0);
    assign w_full  = (r_count == FIFO_FULL);
    assign w_pop   = m_valid && m_ready;
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign m_data  = m_valid ? r_mem[r_rd_ptr] : '0;

    // FIFO storage; contents are don't-care until counted valid
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= v_in;
    end

    // FIFO pointers, occupancy and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_arm)
                r_overflow <= 1'b0;
            else if (w_push && !w_wr_en)
                r_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_step_response_monitor.sv
// Bench for step_response_monitor: table of step scenarios plus hand-written
// backpressure, re-arm and mid-run reset sequences; trace checked by scoreboard.
module tb_step_response_monitor;
    localparam int W  = 18;
    localparam int TW = 6;

    logic          clk = 1'b0;
    logic          rst_n, start, m_ready;
    logic [W-1:0]  v_in, target, tol, m_data, peak;
    logic          m_valid, busy, done, settled, overflow;
    logic [TW-1:0] settle_time;

    int n_chk = 0;
    int n_fail = 0;
    int n_pop = 0;
    logic [W-1:0] sb[$];

    typedef struct {
        logic signed [W-1:0] target, tol, v0, v1, v2, vg;
        int t1, t2, tg;
        bit ramp, exp_settled;
        int exp_st;
        logic signed [W-1:0] exp_peak;
        int exp_done_t;
    } vec_t;

    step_response_monitor #(.WIDTH(W), .DECIM(4), .SETTLE_COUNT(16),
                            .TIMER_WIDTH(TW), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .v_in(v_in), .target(target),
        .tol(tol), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .settled(settled), .settle_time(settle_time),
        .peak(peak), .overflow(overflow));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, $signed(act), $signed(exp));
        end
    endtask

    function automatic vec_t mk(input int tg_, tl, a, b, c, g, t1, t2, tg, rp, es, est, epk, edt);
        vec_t r;
        r.target = W'(tg_); r.tol = W'(tl);
        r.v0 = W'(a); r.v1 = W'(b); r.v2 = W'(c); r.vg = W'(g);
        r.t1 = t1; r.t2 = t2; r.tg = tg;
        r.ramp = rp[0]; r.exp_settled = es[0]; r.exp_st = est;
        r.exp_peak = W'(epk); r.exp_done_t = edt;
        return r;
    endfunction

    function automatic logic [W-1:0] vfun(input vec_t r, input int t);
        if (r.ramp)     return W'(t);
        if (t == r.tg)  return r.vg;
        if (t < r.t1)   return r.v0;
        if (t < r.t2)   return r.v1;
        return r.v2;
    endfunction

    // Trace scoreboard: every transfer must match the oldest expected sample
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            n_pop++;
            if (sb.size() == 0) chk("trace_unexpected", 64'(m_data), 64'hFFFF_FFFF);
            else                chk("trace_data", 64'(m_data), 64'(sb.pop_front()));
        end
    end

    task automatic run_vec(input vec_t r);
        int t;
        bit fin;
        logic exp_ovf;
        logic [W-1:0] v;
        exp_ovf = 1'b0;
        target = r.target; tol = r.tol; v_in = vfun(r, 0); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("arm_busy", 64'(busy), 64'd1);
        chk("arm_peak", 64'(peak), 64'h20000);
        chk("arm_ovf", 64'(overflow), 64'd0);
        t = 0; fin = 1'b0;
        while (!fin) begin
            v = vfun(r, t);
            v_in = v;
            if (t == 0 && m_ready) chk("empty_before_push", 64'(m_valid), 64'd0);
            if (t == 1 && m_ready) chk("push_latency", 64'(m_valid), 64'd1);
            if (t % 4 == 0) begin
                if (sb.size() >= 8 && !m_ready) exp_ovf = 1'b1;
                else                            sb.push_back(v);
            end
            @(posedge clk); #1;
            if (r.ramp) chk($sformatf("overflow_t%0d", t), 64'(overflow), 64'(exp_ovf));
            if (done) fin = 1'b1;
            else if (t >= 80) begin
                n_chk++; n_fail++;
                $display("FAIL done_wait: no done after %0d cycles", t);
                fin = 1'b1;
            end else t++;
        end
        chk("done_t", 64'(t), 64'(r.exp_done_t));
        chk("busy_low", 64'(busy), 64'd0);
        chk("settled", 64'(settled), 64'(r.exp_settled));
        chk("settle_time", 64'(settle_time), 64'(r.exp_st));
        chk("peak", 64'($signed(peak)), 64'(r.exp_peak));
    endtask

    task automatic drain(input int n);
        m_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vecs[8];
        vec_t ramp;
        int p0;
        vecs[0] = mk(1000, 10, 1000, 1000, 1000, 0, 0, 0, -1, 0, 1, 0, 1000, 15);
        vecs[1] = mk(1000, 10, 0, 1100, 1005, 0, 20, 25, -1, 0, 1, 25, 1100, 40);
        vecs[2] = mk(1000, 10, 0, 1100, 1005, 1011, 20, 25, 30, 0, 1, 31, 1100, 46);
        vecs[3] = mk(-500, 20, -480, -480, -480, 0, 0, 0, -1, 0, 1, 0, -480, 15);
        vecs[4] = mk(-500, 20, -521, -521, -521, 0, 0, 0, -1, 0, 0, 63, -521, 63);
        vecs[5] = mk(-131072, 1, 131071, 131071, 131071, 0, 0, 0, -1, 0, 0, 63, 131071, 63);
        vecs[6] = mk(0, 5, 50, -3000, -4, 0, 10, 12, -1, 0, 1, 12, 50, 27);
        vecs[7] = mk(0, 0, 7, 7, 0, 0, 48, 48, -1, 0, 1, 48, 7, 63);
        ramp    = mk(1000, 0, 0, 0, 0, 0, 0, 0, -1, 1, 0, 63, 63, 63);

        rst_n = 1'b0; start = 1'b0; m_ready = 1'b0;
        v_in = '0; target = '0; tol = '0;
        repeat (4) begin
            @(posedge clk); #1;
            start = ~start; m_ready = ~m_ready; v_in = W'($urandom);
        end
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_settled", 64'(settled), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_st", 64'(settle_time), 64'd0);
        chk("rst_peak", 64'(peak), 64'h20000);
        chk("rst_mdata", 64'(m_data), 64'd0);
        chk("rst_mvalid", 64'(m_valid), 64'd0);
        start = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        drain(2);

        foreach (vecs[i]) begin
            drain(8);
            run_vec(vecs[i]);
            drain(8);
            chk("done_hold", 64'(done), 64'd1);
            chk("st_hold", 64'(settle_time), 64'(vecs[i].exp_st));
        end

        // Backpressure: stalled sink fills the FIFO, later pushes are dropped
        m_ready = 1'b0;
        run_vec(ramp);
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_head", 64'(m_data), 64'd0);
        p0 = n_pop;
        drain(14);
        chk("drain_count", 64'(n_pop - p0), 64'd8);
        chk("drain_sb_empty", 64'(sb.size()), 64'd0);
        chk("drain_valid", 64'(m_valid), 64'd0);

        // Re-arm from DONE with a full FIFO, then reset mid-track
        m_ready = 1'b0;
        run_vec(ramp);
        start = 1'b1; v_in = '0;
        @(posedge clk); #1 start = 1'b0;
        chk("rearm_ovf", 64'(overflow), 64'd0);
        chk("rearm_peak", 64'(peak), 64'h20000);
        chk("rearm_valid", 64'(m_valid), 64'd1);
        chk("rearm_head", 64'(m_data), 64'd0);
        for (int t = 0; t < 10; t++) begin
            v_in = W'(t);
            @(posedge clk); #1;
        end
        chk("rearm_drop_ovf", 64'(overflow), 64'd1);
        chk("rearm_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_valid", 64'(m_valid), 64'd0);
        chk("midrst_ovf", 64'(overflow), 64'd0);
        chk("midrst_peak", 64'(peak), 64'h20000);
        chk("midrst_done", 64'(done), 64'd0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;

        drain(4);
        run_vec(vecs[0]);
        drain(8);
        chk("final_sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
